// File: rtl/datapath_pkg.sv
// Shared encodings, status layout and flag helpers for datapath_gen2.
package datapath_pkg;

    typedef enum logic [1:0] {
        VSEL_MDATA = 2'b00,
        VSEL_IMM8  = 2'b01,
        VSEL_PC    = 2'b10,
        VSEL_C     = 2'b11
    } vsel_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } aluop_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } status_t;

    // Signed overflow of an addition, given the MSBs of both addends and of the sum.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/regfile_p.sv
// Parametrised register file: one synchronous write port, one combinational
// read port, with write data bypassed to the read port on an index match.
module regfile_p
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [RW-1:0]    writenum,
    input  logic [RW-1:0]    readnum,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] we_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            assign we_onehot[gi] = write && (writenum == RW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n) begin
                regs_reg[i] <= '0;
            end else if (we_onehot[i]) begin
                regs_reg[i] <= data_in;
            end
        end
    end

    // Bypass lets a same-cycle loada/loadb capture the value being written.
    assign data_out = (write && (writenum == readnum)) ? data_in : regs_reg[readnum];

endmodule

// File: rtl/datapath_gen2.sv
// Second-generation datapath: register file, A/B operands, B shifter, ALU,
// result register C and Z/N/V/C status, all sequenced by an external controller.
module datapath_gen2
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       vsel,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [PC_W-1:0]  PC,
    input  logic             write,
    input  logic [RW-1:0]    writenum,
    input  logic [RW-1:0]    readnum,
    input  logic             loada,
    input  logic             loadb,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       shift,
    input  logic [1:0]       ALUop,
    input  logic             loadc,
    input  logic             loads,
    output logic [WIDTH-1:0] datapath_out,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out,
    output logic             C_out
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    status_t          status_reg;
    status_t          status_next;
    logic [WIDTH-1:0] b_shift, ain, bin, b_addend, alu_res;
    logic [WIDTH:0]   sum;
    logic             is_sub;

    always_comb begin
        data_in = mdata;
        case (vsel_e'(vsel))
            VSEL_MDATA: data_in = mdata;
            VSEL_IMM8:  data_in = sximm8;
            VSEL_PC:    data_in = WIDTH'(PC);
            VSEL_C:     data_in = c_reg;
            default:    data_in = mdata;
        endcase
    end

    regfile_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .write    (write),
        .writenum (writenum),
        .readnum  (readnum),
        .data_in  (data_in),
        .data_out (rd_data)
    );

    always_comb begin
        b_shift = b_reg;
        case (shift_e'(shift))
            SH_NONE: b_shift = b_reg;
            SH_LSL1: b_shift = {b_reg[WIDTH-2:0], 1'b0};
            SH_LSR1: b_shift = {1'b0, b_reg[WIDTH-1:1]};
            SH_ASR1: b_shift = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
            default: b_shift = b_reg;
        endcase
    end

    assign ain = asel ? '0 : a_reg;
    assign bin = bsel ? sximm5 : b_shift;

    // Subtract shares the adder: Ain + ~Bin + 1, so carry-out means "no borrow".
    assign is_sub   = (aluop_e'(ALUop) == ALU_SUB);
    assign b_addend = is_sub ? ~bin : bin;
    assign sum      = {1'b0, ain} + {1'b0, b_addend} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        alu_res       = sum[WIDTH-1:0];
        status_next.c = 1'b0;
        status_next.v = 1'b0;
        case (aluop_e'(ALUop))
            ALU_ADD, ALU_SUB: begin
                alu_res       = sum[WIDTH-1:0];
                status_next.c = sum[WIDTH];
                status_next.v = add_overflow(ain[WIDTH-1], b_addend[WIDTH-1], sum[WIDTH-1]);
            end
            ALU_AND: alu_res = ain & bin;
            ALU_NOT: alu_res = ~bin;
            default: alu_res = sum[WIDTH-1:0];
        endcase
        status_next.z = (alu_res == '0);
        status_next.n = alu_res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            status_reg <= '0;
        end else begin
            if (loada) a_reg <= rd_data;
            if (loadb) b_reg <= rd_data;
            if (loadc) c_reg <= alu_res;
            if (loads) status_reg <= status_next;
        end
    end

    assign datapath_out = c_reg;
    assign Z_out        = status_reg.z;
    assign N_out        = status_reg.n;
    assign V_out        = status_reg.v;
    assign C_out        = status_reg.c;

endmodule

// File: doc/datapath_gen2.md
Name: datapath_gen2

Overview:
Parametrised second-generation datapath: register file, A/B operand registers, shifter, ALU, result register C and status register.
Generalises the 16-bit, 8-register datapath in word width, register count and PC width. Adds synchronous reset, arithmetic shift right, a carry flag and same-cycle write-to-read forwarding.
Driven cycle-by-cycle by the CPU controller FSM, which supplies every load and select strobe.

Parameters:
WIDTH, 16, datapath word width in bits (>= 4)
NREGS, 8, number of general registers (power of two, >= 2); RW = $clog2(NREGS)
PC_W, 8, width of PC input; zero-extended to WIDTH (PC_W <= WIDTH)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
vsel  in  2  write-back source: 00 mdata, 01 sximm8, 10 PC zero-extended, 11 C
mdata  in  WIDTH  memory read data
sximm8  in  WIDTH  sign-extended 8-bit immediate
sximm5  in  WIDTH  sign-extended 5-bit immediate
PC  in  PC_W  program counter
write  in  1  register file write enable
writenum  in  RW  register file write index
readnum  in  RW  register file read index
loada  in  1  load A from read data
loadb  in  1  load B from read data
asel  in  1  ALU operand A: 0 = A register, 1 = zero
bsel  in  1  ALU operand B: 0 = shifted B, 1 = sximm5
shift  in  2  00 none, 01 LSL1, 10 LSR1 (MSB <- 0), 11 ASR1 (MSB kept)
ALUop  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B
loadc  in  1  load C from ALU result
loads  in  1  load status flags
datapath_out  out  WIDTH  contents of C
Z_out  out  1  zero flag
N_out  out  1  negative flag (result MSB)
V_out  out  1  signed overflow flag
C_out  out  1  carry / no-borrow flag

Behaviour:
- Reset: when rst_n = 0 at posedge, all registers R0..R(NREGS-1), A, B, C and the Z/N/V/C flags clear to 0. Reset overrides every load/write strobe in the same cycle. Outputs read 0 from the cycle after that edge.
- Register file write: at posedge when write = 1, R[writenum] <= data_in (the value chosen by vsel).
- Register file read: combinational read of R[readnum].
- Forwarding: if write = 1 and writenum == readnum, read data = data_in, not the stale register. A loada/loadb in that same cycle therefore captures the new value.
- A/B registers: load at posedge when their enable is 1; otherwise they hold. loada and loadb may both be 1 in the same cycle.
- Shifter: acts on B only, purely combinational.
- ALU (combinational, WIDTH bits):
  - Add: Ain + Bin.
  - Sub: Ain + ~Bin + 1.
  - Carry: C = carry-out of the sum; for subtract this means C = 1 when there is no borrow (Ain >= Bin unsigned).
  - Overflow: V = operands have the same sign and the result sign differs (for subtract, compare against ~Bin).
  - AND and NOT: C = 0, V = 0.
- Result and flags:
  - C <= result when loadc = 1.
  - When loads = 1: Z <= (result == 0), N <= result[WIDTH-1], V and C as computed above.
  - loadc and loads are independent; flags may update without C and vice versa.
- Latency:
  - Register file to A/B: 1 cycle.
  - A/B to C/flags: 1 cycle.
  - C to register via vsel = 11: 1 cycle.
  - datapath_out is the registered C.
- Simultaneous write and loadc: the register write uses the old C; C updates on the same edge.
- Reset during a multi-cycle operation abandons it; there is no partial state.

Decomposition:
- Package datapath_pkg holds:
  - Enum typedefs for vsel, shift and ALUop encodings.
  - A status struct {Z, N, V, C}.
  - A helper function for overflow computation.
- Sub-module regfile_p (WIDTH, NREGS), containing the storage, the write decoder, the read mux and the forwarding path.
- The shifter and ALU stay inline.

Test Plan (WIDTH=16, NREGS=8):
1. Hold rst_n = 0 for 1 edge after arbitrary prior writes -> datapath_out = 0x0000 and Z/N/V/C = 0; then readnum = 3, loadb, asel = 1, add, loadc -> out = 0x0000.
2. Basic ops:
   - MOV R0, #1 (vsel = 01, sximm8 = 0x0001) and MOV R1, #8.
   - ADD R2, R1, R0 -> out = 0x0009, Z = 0.
   - Write back with vsel = 11; read R2 through B -> 0x0009.
3. Subtract:
   - R1 - (R0 LSL1) -> 0x0006, C = 1, N = 0, V = 0.
   - R0 - R1 -> 0xFFF9, N = 1, C = 0, V = 0.
4. Shifts: R3 = 0x8000; asel = 1, add with shift = 11 -> 0xC000, N = 1; with shift = 10 -> 0x4000, N = 0.
5. Flag edge cases:
   - R5 = 0x7FFF, add R0 (0x0001) -> 0x8000, V = 1, N = 1, C = 0.
   - 0xFFFF + 0x0001 -> 0x0000, Z = 1, C = 1, V = 0.
   - AND of R1 and R0 -> 0x0000, Z = 1.
6. Forwarding and mid-operation reset:
   - write = 1, writenum = 2, vsel = 01, sximm8 = 0x0005, readnum = 2, loada = 1 in one cycle -> A = 0x0005.
   - rst_n = 0 together with loadc = 1 -> C = 0x0000.
